// File: rtl/alu_psr.sv
// ALU with processor status register: single-cycle arithmetic, logic and shift ops,
// plus an iterative shift-add multiplier that holds off new requests while it runs.
module alu_psr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [7:0]       Opcode,
    output logic [WIDTH-1:0] C,
    output logic             out_valid,
    output logic [4:0]       Flags,
    input  logic             psr_we,
    input  logic [4:0]       psr_in
);

    // state    | meaning
    // IDLE     | accepting requests, single-cycle ops complete at the next edge
    // MUL_BUSY | shift-add multiply in progress, in_ready low

    localparam int SW = $clog2(WIDTH);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_NOT  = 8'h0F;
    localparam logic [7:0] OP_RSH  = 8'h4F;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ARSH = 8'h88;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] c_nxt;
    logic [4:0]       psr_nxt;
    logic             ov_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, mcand, mcand_nxt, mplier, mplier_nxt;
    logic [SW-1:0]    cnt, cnt_nxt;

    logic             cin;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum, diff, acc_step;
    logic             add_ovf, sub_ovf;
    logic [SW-1:0]    shamt;

    // ADD and ADDC share one adder; ADDC pulls in the PSR carry as it stands now
    assign cin      = (Opcode == OP_ADDC) ? Flags[0] : 1'b0;
    assign add_full = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(cin);
    assign sum      = add_full[WIDTH-1:0];
    assign diff     = A - B;
    assign add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    assign shamt    = B[SW-1:0];
    assign acc_step = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nxt  = state;
        c_nxt      = C;
        psr_nxt    = Flags;
        ov_nxt     = 1'b0;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        in_ready   = (state == IDLE);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    ov_nxt = 1'b1;
                    case (Opcode)
                        OP_ADD, OP_ADDC: begin
                            c_nxt   = sum;
                            psr_nxt = {sum[WIDTH-1], (sum == '0), add_ovf, Flags[1], add_full[WIDTH]};
                        end
                        OP_SUB: begin
                            c_nxt   = diff;
                            psr_nxt = {diff[WIDTH-1], (diff == '0), sub_ovf, Flags[1], (A < B)};
                        end
                        OP_CMP: begin
                            c_nxt   = '0;
                            psr_nxt = {($signed(A) < $signed(B)), (A == B), Flags[2], (A < B), Flags[0]};
                        end
                        OP_ADDU: c_nxt = sum;
                        OP_AND:  c_nxt = A & B;
                        OP_OR:   c_nxt = A | B;
                        OP_XOR:  c_nxt = A ^ B;
                        OP_NOT:  c_nxt = ~A;
                        OP_LSH:  c_nxt = A << shamt;
                        OP_RSH:  c_nxt = A >> shamt;
                        OP_ARSH: c_nxt = WIDTH'($signed(A) >>> shamt);
                        OP_MUL: begin
                            ov_nxt     = 1'b0;
                            state_nxt  = MUL_BUSY;
                            acc_nxt    = '0;
                            mcand_nxt  = A;
                            mplier_nxt = B;
                            cnt_nxt    = SW'(WIDTH-1);
                        end
                        OP_NOP:  c_nxt = '0;
                        default: c_nxt = '0;
                    endcase
                end
            end
            MUL_BUSY: begin
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                if (cnt == '0) begin
                    c_nxt     = acc_step;
                    ov_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - SW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // a context restore overrides any flag update landing on the same edge
        if (psr_we) psr_nxt = psr_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            C         <= '0;
            Flags     <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            C         <= c_nxt;
            Flags     <= psr_nxt;
            out_valid <= ov_nxt;
            acc       <= acc_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_alu_psr.sv
// Directed-vector bench for alu_psr at WIDTH=16; inputs driven and outputs sampled on the falling edge.
module tb_alu_psr;

    localparam logic [7:0] ADD = 8'h05, ADDU = 8'h06, ADDC = 8'h07, SUB = 8'h09, CMP = 8'h0B;
    localparam logic [7:0] AND_ = 8'h01, OR_ = 8'h02, XOR_ = 8'h03, NOT_ = 8'h0F;
    localparam logic [7:0] LSH = 8'h84, RSH = 8'h4F, ARSH = 8'h88, MUL = 8'h0E;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, psr_we;
    logic [15:0] A, B, C;
    logic [7:0]  Opcode;
    logic [4:0]  Flags, psr_in;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_psr #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Opcode(Opcode), .C(C), .out_valid(out_valid),
        .Flags(Flags), .psr_we(psr_we), .psr_in(psr_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // offer one request at the current falling edge, check its result one cycle later;
    // in_valid stays high so consecutive calls run back-to-back
    task automatic run1(input string tag, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ec, input logic [4:0] ef);
        in_valid = 1'b1; Opcode = op; A = a; B = b;
        @(negedge clk);
        chk({tag, "_c"}, C, ec);
        chk({tag, "_ov"}, out_valid, 1'b1);
        chk({tag, "_flags"}, Flags, ef);
    endtask

    task automatic setpsr(input logic [4:0] v);
        in_valid = 1'b0; psr_we = 1'b1; psr_in = v;
        @(negedge clk);
        psr_we = 1'b0;
        chk("psr_load", Flags, v);
    endtask

    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ec, input logic [4:0] ef);
        int busy = 0;
        in_valid = 1'b1; Opcode = MUL; A = a; B = b;
        @(negedge clk);
        // keep a second request on the bus for the whole busy window
        Opcode = ADD; A = 16'h0001; B = 16'h0001;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (!in_ready && !out_valid) busy++;
        end
        @(negedge clk);
        chk("mul_busy_cycles", busy, 16);
        chk("mul_ov", out_valid, 1'b1);
        chk("mul_c", C, ec);
        chk("mul_ready", in_ready, 1'b1);
        chk("mul_flags", Flags, ef);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mul_second_not_taken", out_valid, 1'b0);
        chk("mul_c_hold", C, ec);
    endtask

    logic [7:0]  tv_op [0:10] = '{AND_, OR_, XOR_, NOT_, LSH, RSH, RSH, ARSH, ARSH, ADDU, 8'h55};
    logic [15:0] tv_a  [0:10] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0001, 16'h8000, 16'h8001,
                                  16'h8000, 16'h4000, 16'hFFFF, 16'h1234};
    logic [15:0] tv_b  [0:10] = '{16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0000, 16'h0013, 16'h000F, 16'h0010,
                                  16'h0004, 16'h0002, 16'h0002, 16'h5678};
    logic [15:0] tv_c  [0:10] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0F0F, 16'h0008, 16'h0001, 16'h8001,
                                  16'hF800, 16'h1000, 16'h0001, 16'h0000};

    initial begin
        int ovs;
        // garbage requests and PSR loads during reset must be ignored
        reset = 1'b1; in_valid = 1'b1; Opcode = ADD; A = 16'h0005; B = 16'h0005;
        psr_we = 1'b1; psr_in = 5'b11111;
        repeat (3) @(negedge clk);
        chk("rst_c", C, 16'h0000);
        chk("rst_flags", Flags, 5'b00000);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        reset = 1'b0; in_valid = 1'b0; psr_we = 1'b0;

        run1("add_ovf", ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b10100);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ov_single_pulse", out_valid, 1'b0);
        chk("c_hold", C, 16'h8000);

        setpsr(5'b00000);
        run1("add_carry", ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b01001);
        run1("addc_b2b", ADDC, 16'h0000, 16'h0000, 16'h0001, 5'b00000);

        setpsr(5'b00101);
        run1("cmp_ult", CMP, 16'h0001, 16'hFFFF, 16'h0000, 5'b00111);
        run1("sub_borrow", SUB, 16'h0003, 16'h0005, 16'hFFFE, 5'b10011);
        run1("sub_ovf", SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00110);
        run1("sub_zero", SUB, 16'h1234, 16'h1234, 16'h0000, 5'b01010);
        run1("cmp_slt", CMP, 16'h8000, 16'h0001, 16'h0000, 5'b10000);

        for (int i = 0; i < 11; i++)
            run1($sformatf("tv%0d", i), tv_op[i], tv_a[i], tv_b[i], tv_c[i], 5'b10000);
        in_valid = 1'b0;
        @(negedge clk);

        do_mul(16'h0003, 16'h0005, 16'h000F, 5'b10000);
        do_mul(16'h00FF, 16'h0101, 16'hFFFF, 5'b10000);

        // reset part-way through a multiply
        in_valid = 1'b1; Opcode = MUL; A = 16'hFFFF; B = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mulrst_ready", in_ready, 1'b1);
        chk("mulrst_c", C, 16'h0000);
        chk("mulrst_flags", Flags, 5'b00000);
        ovs = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) ovs++;
            @(negedge clk);
        end
        chk("mulrst_no_ov", ovs, 0);

        psr_we = 1'b1; psr_in = 5'b11111;
        run1("psr_we_wins", ADD, 16'h0001, 16'h0001, 16'h0002, 5'b11111);
        psr_we = 1'b0;
        run1("addc_after_load", ADDC, 16'h0001, 16'h0001, 16'h0003, 5'b00010);
        in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
